// File: rtl/decimal_subtractor_serial_if.sv
// Request/response bundle for decimal_subtractor_serial: packed BCD operands in,
// packed BCD difference, borrow, error and done/busy status out.
interface decimal_subtractor_serial_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   minuend;
  logic [4*DIGITS-1:0]   subtrahend;
  logic                  Bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  Bout;
  logic                  err;

  modport master (
    output start, minuend, subtrahend, Bin,
    input  busy, done, diff, Bout, err
  );

  modport slave (
    input  start, minuend, subtrahend, Bin,
    output busy, done, diff, Bout, err
  );
endinterface

// File: rtl/decimal_subtractor_serial.sv
// Digit-serial BCD subtractor (LSD first, one digit per clock).
// Define DEC_SUB_BCD_CHECK_EN to flag non-BCD operand nibbles via err.
module bcd_sub_digit (
  input  logic [3:0] m_i,
  input  logic [3:0] s_i,
  input  logic       b_i,
  output logic [3:0] d_o,
  output logic       b_o
);
  logic [4:0] t;

  // 5-bit two's complement covers -16..15, so bit 4 is the borrow
  assign t   = {1'b0, m_i} - {1'b0, s_i} - {4'b0, b_i};
  assign b_o = t[4];
  assign d_o = t[4] ? (t[3:0] + 4'd10) : t[3:0];
endmodule

module decimal_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  decimal_subtractor_serial_if.slave    bus
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    m_q, m_d, s_q, s_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            brw_q, brw_d;
  logic            bout_q, bout_d;
  logic [3:0]      dig_d;
  logic            dig_b;
  logic [W-1:0]    dwide;

  bcd_sub_digit u_dig (
    .m_i (m_q[3:0]),
    .s_i (s_q[3:0]),
    .b_i (brw_q),
    .d_o (dig_d),
    .b_o (dig_b)
  );

`ifdef DEC_SUB_BCD_CHECK_EN
  logic err_q, err_d;
  logic bad_q, bad_d;
  logic bad_in;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.minuend[4*i +: 4] > 4'd9 || bus.subtrahend[4*i +: 4] > 4'd9)
        bad_in = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    m_d     = m_q;
    s_d     = s_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef DEC_SUB_BCD_CHECK_EN
    err_d   = err_q;
    bad_d   = bad_q;
`endif
    dwide            = '0;
    dwide[W-1 -: 4]  = dig_d;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.minuend;
          s_d     = bus.subtrahend;
          brw_d   = bus.Bin;
          idx_d   = '0;
          res_d   = '0;
`ifdef DEC_SUB_BCD_CHECK_EN
          bad_d   = bad_in;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // operands shift down so the active digit is always nibble 0;
        // results shift in from the top and land LSD-aligned after DIGITS steps
        m_d   = m_q >> 4;
        s_d   = s_q >> 4;
        brw_d = dig_b;
        res_d = (res_q >> 4) | dwide;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(DIGITS - 1)) begin
          state_d = DONE;
          diff_d  = res_d;
          bout_d  = dig_b;
`ifdef DEC_SUB_BCD_CHECK_EN
          err_d   = bad_q;
          if (bad_q) begin
            diff_d = '0;
            bout_d = 1'b0;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      m_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef DEC_SUB_BCD_CHECK_EN
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      s_q     <= s_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
`ifdef DEC_SUB_BCD_CHECK_EN
      err_q   <= err_d;
      bad_q   <= bad_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.Bout = bout_q;
`ifdef DEC_SUB_BCD_CHECK_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif
endmodule
